uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `UART_Tx` transmitter between `NUM_REQ` byte-stream requesters. It accepts one byte at a time from the winning requester and issues it to the UART as a single-cycle `data_en` pulse. It then tracks the UART's `tx_done` handshake until the transmitter is back in idle, and reports completion or timeout to the requester. It sits between the client logic and `UART_Tx`, and drives that transmitter's `data_en`/`data` inputs directly.

---
 rtl/uart_tx_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters. In IDLE
// a round-robin search picks one valid requester, and its byte is accepted. The
// byte goes to the UART as a single-cycle data_en strobe. The block then follows
// the UART's tx_done handshake until the transmitter is idle again. Completion
// is reported with req_done. A transfer that exceeds TIMEOUT_CYCLES in BUSY is
// reported with req_err.
//
// Parameters
//   NUM_REQ         number of requesters (2..16)
//   TIMEOUT_CYCLES  maximum cycles spent in BUSY+DRAIN before abort (>= 16)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   req_valid     per-requester byte pending
//   req_data      byte of requester i in bits [8i+7:8i]
//   req_ready     combinational one-hot accept (IDLE only)
//   req_done      registered one-cycle completion pulse, one bit per requester
//   req_err       registered one-cycle timeout pulse, one bit per requester
//   uart_data_en  registered one-cycle issue strobe to the UART
//   uart_data     registered byte to the UART, stable until back in IDLE
//   uart_tx_done  UART end-of-byte indication (high for >= 2 cycles)
//   busy          registered, high whenever the state is not IDLE
//   grant_idx     registered index of the current or most recent grant
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_err,
    output logic                 uart_data_en,
    output logic [7:0]           uart_data,
    input  logic                 uart_tx_done,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx
);

    // The counter must hold TIMEOUT_CYCLES and is never narrower than 16 bits.
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 16) ? 16 : CNT_RAW;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [7:0]           uart_data_q, uart_data_d;
    logic                 uart_data_en_q, uart_data_en_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   req_done_q, req_done_d;
    logic [NUM_REQ-1:0]   req_err_q, req_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0][7:0] req_bytes;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic                    accept;
    logic                    timeout;

    assign req_bytes = req_data;

    // Round-robin search starting one past the last winner, with wrap-around.
    always_comb begin
        int cand;
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path through the block leaves a latch behind.
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            if (!sel_found && req_valid[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Ready is offered only in IDLE and never while reset is held.
    assign accept = !rst && (state_q == IDLE) && sel_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_idx_d    = grant_idx_q;
        uart_data_d    = uart_data_q;
        uart_data_en_d = 1'b0;
        req_done_d     = '0;
        req_err_d      = '0;
        cnt_d          = cnt_q;
        timeout        = (cnt_q >= TMO_LAST);

        case (state_q)
            IDLE: begin
                // tx_done is ignored here.
                if (accept) begin
                    uart_data_d    = req_bytes[sel_idx];
                    grant_idx_d    = sel_idx;
                    last_grant_d   = sel_idx;
                    cnt_d          = '0;
                    uart_data_en_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                // The strobe is high during this cycle. A tx_done still high
                // from earlier activity is ignored.
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion seen on the same cycle as the timeout wins:
                // the byte went out, so it is reported as done.
                if (uart_tx_done) begin
                    req_done_d[grant_idx_q] = 1'b1;
                    state_d                 = DRAIN;
                end else if (timeout) begin
                    req_err_d[grant_idx_q] = 1'b1;
                    state_d                = IDLE;
                end
            end
            DRAIN: begin
                // Hold off until tx_done drops. This stops a multi-cycle
                // tx_done from counting twice and keeps the UART idle before
                // the next strobe. Done has already fired, so a timeout here
                // just returns to IDLE.
                cnt_d = cnt_q + CNT_W'(1);
                if (!uart_tx_done || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // values from before the edge, independent of statement order.
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            grant_idx_q    <= '0;
            uart_data_q    <= 8'h00;
            uart_data_en_q <= 1'b0;
            busy_q         <= 1'b0;
            req_done_q     <= '0;
            req_err_q      <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_idx_q    <= grant_idx_d;
            uart_data_q    <= uart_data_d;
            uart_data_en_q <= uart_data_en_d;
            busy_q         <= busy_d;
            req_done_q     <= req_done_d;
            req_err_q      <= req_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign req_done     = req_done_q;
    assign req_err      = req_err_q;
    assign uart_data_en = uart_data_en_q;
    assign uart_data    = uart_data_q;
    assign busy         = busy_q;
    assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. A small UART model answers each data_en:
// it stays busy for one byte time (10 bits x 4 clocks) and then holds tx_done
// high for done_len cycles. A second instance has TIMEOUT_CYCLES = 16 and its
// tx_done is tied low, so it exercises the abort path.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int BYTE_CYC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready, req_done, req_err;
    logic        uart_data_en, uart_tx_done, busy;
    logic [7:0]  uart_data;
    logic [1:0]  grant_idx;

    // timeout instance
    logic [3:0]  to_valid;
    logic [31:0] to_data;
    logic [3:0]  to_ready, to_done, to_err;
    logic        to_data_en, to_busy;
    logic [7:0]  to_udata;
    logic [1:0]  to_grant;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(65535)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .req_done(req_done), .req_err(req_err),
        .uart_data_en(uart_data_en), .uart_data(uart_data),
        .uart_tx_done(uart_tx_done), .busy(busy), .grant_idx(grant_idx)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) u_to (
        .clk(clk), .rst(rst),
        .req_valid(to_valid), .req_data(to_data), .req_ready(to_ready),
        .req_done(to_done), .req_err(to_err),
        .uart_data_en(to_data_en), .uart_data(to_udata),
        .uart_tx_done(1'b0), .busy(to_busy), .grant_idx(to_grant)
    );

    // cycle counter: during the cycle after edge k it reads k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model
    int m_cnt    = 0;
    int done_len = 2;
    always @(posedge clk) begin
        if (rst)               m_cnt <= 0;
        else if (uart_data_en) m_cnt <= BYTE_CYC + done_len;
        else if (m_cnt != 0)   m_cnt <= m_cnt - 1;
    end
    assign uart_tx_done = (m_cnt != 0) && (m_cnt <= done_len);

    // monitors
    int          done_cnt [4] = '{0, 0, 0, 0};
    int          err_cnt     = 0;
    int          to_done_cnt = 0;
    int          reissue_bad = 0;
    logic [7:0]  log_byte [$];
    logic [1:0]  log_idx  [$];
    int          log_cyc  [$];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
        if (req_err != 4'b0000 && !$isunknown(req_err)) err_cnt <= err_cnt + 1;
        if (to_done != 4'b0000 && !$isunknown(to_done)) to_done_cnt <= to_done_cnt + 1;
        if (uart_data_en === 1'b1) begin
            log_byte.push_back(uart_data);
            log_idx.push_back(grant_idx);
            log_cyc.push_back(cyc);
            if (uart_tx_done) reissue_bad <= reissue_bad + 1;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_byte.delete();
        log_idx.delete();
        log_cyc.delete();
    endtask

    task automatic wait_done(input int budget, output int at, output logic [3:0] val);
        at  = -1;
        val = 4'b0000;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_done != 4'b0000) begin
                at  = cyc;
                val = req_done;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_issues(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (log_byte.size() >= n) break;
        end
        check(tag, log_byte.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected summary before 1 ms");
        $fatal(1);
    end

    initial begin
        int         t0;
        int         at;
        int         snap_d;
        int         snap_e;
        logic [3:0] val;
        logic [7:0] exp_rr_b [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [1:0] exp_rr_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_lg_b [3] = '{8'h21, 8'h23, 8'h21};
        logic [1:0] exp_lg_i [3] = '{2'd1, 2'd3, 2'd1};

        req_valid = 4'hF;
        req_data  = '0;
        to_valid  = '0;
        to_data   = '0;

        // ---- reset values (valid held high during reset) ----
        tick();
        tick();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_data_en", uart_data_en, 0);
        check("rst_data", uart_data, 8'h00);
        check("rst_grant", grant_idx, 0);
        check("rst_done", req_done, 4'b0000);
        check("rst_err", req_err, 4'b0000);
        req_valid = '0;
        rst       = 1'b0;
        tick();
        check("idle_no_valid_ready", req_ready, 4'b0000);

        // ---- single requester 2, byte 0xA5 ----
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        #1;
        t0 = cyc;
        check("t1_ready", req_ready, 4'b0100);
        tick();
        check("t1_data_en", uart_data_en, 1);
        check("t1_data", uart_data, 8'hA5);
        check("t1_busy", busy, 1);
        check("t1_grant", grant_idx, 2);
        check("t1_ready_busy", req_ready, 4'b0000);
        req_valid = '0;
        tick();
        check("t1_en_one_cycle", uart_data_en, 0);
        wait_done(100, at, val);
        check("t1_done_cycle", at, t0 + 43);
        check("t1_done_bit", val, 4'b0100);
        wait_idle(100, at);
        check("t1_idle_cycle", at, t0 + 45);
        check("t1_data_held", uart_data, 8'hA5);
        check("t1_done_once", done_cnt[2], 1);

        // ---- timeout with tx_done tied low ----
        to_data[7:0] = 8'h5A;
        to_valid     = 4'b0001;
        #1;
        t0 = cyc;
        check("to_ready", to_ready, 4'b0001);
        tick();
        to_valid = '0;
        check("to_data_en", to_data_en, 1);
        at  = -1;
        val = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (to_err != 4'b0000) begin
                at  = cyc;
                val = to_err;
                break;
            end
        end
        check("to_err_cycle", at, t0 + 18);
        check("to_err_bit", val, 4'b0001);
        check("to_idle", to_busy, 0);
        check("to_no_done", to_done_cnt, 0);

        // ---- all four continuously valid after reset ----
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
        req_data  = 32'h1312_1110;
        req_valid = 4'hF;
        wait_issues("rr_issues", 5, 400);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_idx%0d", k), log_idx[k], exp_rr_i[k]);
            check($sformatf("rr_byte%0d", k), log_byte[k], exp_rr_b[k]);
        end
        check("rr_spacing", log_cyc[1] - log_cyc[0], 45);
        req_valid = '0;
        wait_idle(200, at);

        // ---- grant order follows last_grant = 1 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        req_data        = '0;
        req_data[15:8]  = 8'h21;
        req_data[31:24] = 8'h23;
        req_valid       = 4'b0010;
        #1;
        check("lg_first_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1010;
        #1;
        check("lg_ready_in_busy", req_ready, 4'b0000);
        wait_issues("lg_issues", 3, 400);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lg_idx%0d", k), log_idx[k], exp_lg_i[k]);
            check($sformatf("lg_byte%0d", k), log_byte[k], exp_lg_b[k]);
        end
        req_valid = '0;
        wait_idle(200, at);

        // ---- tx_done held high for 5 cycles ----
        done_len = 5;
        clear_log();
        snap_d        = done_cnt[0];
        req_data[7:0] = 8'h77;
        req_valid     = 4'b0001;
        wait_issues("hold_issues", 2, 200);
        check("hold_spacing", log_cyc[1] - log_cyc[0], 48);
        check("hold_done_once", done_cnt[0] - snap_d, 1);
        check("hold_no_reissue", reissue_bad, 0);
        req_valid = '0;
        wait_idle(200, at);
        done_len = 2;

        // ---- reset mid-transfer, then a normal request ----
        req_data[31:24] = 8'h3C;
        req_valid       = 4'b1000;
        #1;
        check("rm_ready", req_ready, 4'b1000);
        tick();
        check("rm_grant", grant_idx, 3);
        req_valid = '0;
        repeat (20) tick();
        snap_d          = done_cnt[3];
        snap_e          = err_cnt;
        rst             = 1'b1;
        req_data[15:8]  = 8'h99;
        req_valid       = 4'b0010;
        tick();
        check("rm_ready_in_rst", req_ready, 4'b0000);
        check("rm_busy", busy, 0);
        check("rm_data_en", uart_data_en, 0);
        check("rm_data", uart_data, 8'h00);
        check("rm_grant_rst", grant_idx, 0);
        check("rm_done", req_done, 4'b0000);
        check("rm_err", req_err, 4'b0000);
        rst = 1'b0;
        #1;
        check("rm_next_ready", req_ready, 4'b0010);
        tick();
        check("rm_next_en", uart_data_en, 1);
        check("rm_next_data", uart_data, 8'h99);
        check("rm_next_grant", grant_idx, 1);
        req_valid = '0;
        wait_done(100, at, val);
        check("rm_next_done", val, 4'b0010);
        check("rm_no_done3", done_cnt[3], snap_d);
        check("rm_no_err", err_cnt, snap_e);
        check("main_no_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
